// File: rtl/fpu_arbiter.sv
// Two-requester round-robin front end for a fixed-latency FPU.
// Issued ops are tagged in a shift register so that each result is routed back to the requester that issued it.
module fpu_arbiter #(
    parameter int LAT       = 5,
    parameter int PIPELINED = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [1:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [1:0]  req1_op,
    output logic [31:0] fpu_A,
    output logic [31:0] fpu_B,
    output logic [1:0]  fpu_opcode,
    input  logic [31:0] fpu_outp,
    output logic        rsp0_valid,
    output logic        rsp1_valid,
    output logic [31:0] rsp0_data,
    output logic [31:0] rsp1_data,
    output logic [3:0]  inflight
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic            ptr_r;
    logic            issue_ok_s;
    logic            gnt0_s;
    logic            gnt1_s;
    logic            hs_s;
    logic            ret_s;
    logic            ret_id_s;
    logic [LAT-1:0]  tv_r;
    logic [LAT-1:0]  tid_r;
    logic [31:0]     fpu_a_r;
    logic [31:0]     fpu_b_r;
    logic [1:0]      fpu_op_r;
    logic            rsp0_valid_r;
    logic            rsp1_valid_r;
    logic [31:0]     rsp0_data_r;
    logic [31:0]     rsp1_data_r;
    logic [3:0]      inflight_r;

    // The single-op-in-flight variant only issues from IDLE.
    assign issue_ok_s = (PIPELINED != 0) || (state_r == ST_IDLE);
    assign hs_s       = gnt0_s | gnt1_s;
    assign ret_s      = tv_r[LAT-1];
    assign ret_id_s   = tid_r[LAT-1];

    // Round-robin grant; a grant always implies the requester is valid.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (!rst && issue_ok_s) begin
            if (req0_valid && req1_valid) begin
                gnt0_s = ~ptr_r;
                gnt1_s = ptr_r;
            end else begin
                gnt0_s = req0_valid;
                gnt1_s = req1_valid;
            end
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    // Next-state logic for the issue FSM.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (hs_s) state_nxt_s = ST_BUSY;
                else      state_nxt_s = ST_IDLE;
            end
            ST_BUSY: begin
                if (ret_s) state_nxt_s = ST_IDLE;
                else       state_nxt_s = ST_BUSY;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Issue FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= ST_IDLE;
        else     state_r <= state_nxt_s;
    end

    // Pointer moves to the non-granted side; operands hold between issues.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r    <= 1'b0;
            fpu_a_r  <= 32'd0;
            fpu_b_r  <= 32'd0;
            fpu_op_r <= 2'd0;
        end else if (hs_s) begin
            ptr_r    <= ~gnt1_s;
            fpu_a_r  <= gnt1_s ? req1_a  : req0_a;
            fpu_b_r  <= gnt1_s ? req1_b  : req0_b;
            fpu_op_r <= gnt1_s ? req1_op : req0_op;
        end else begin
            ptr_r    <= ptr_r;
            fpu_a_r  <= fpu_a_r;
            fpu_b_r  <= fpu_b_r;
            fpu_op_r <= fpu_op_r;
        end
    end

    // Tag pipeline: stage LAT-1 marks the edge at which fpu_outp is sampled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tv_r  <= '0;
            tid_r <= '0;
        end else begin
            tv_r[0]  <= hs_s;
            tid_r[0] <= gnt1_s;
            for (int i = 1; i < LAT; i++) begin
                tv_r[i]  <= tv_r[i-1];
                tid_r[i] <= tid_r[i-1];
            end
        end
    end

    // Route the returning result to its requester as a one-cycle strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp0_valid_r <= 1'b0;
            rsp1_valid_r <= 1'b0;
            rsp0_data_r  <= 32'd0;
            rsp1_data_r  <= 32'd0;
        end else begin
            rsp0_valid_r <= ret_s && !ret_id_s;
            rsp1_valid_r <= ret_s && ret_id_s;
            if (ret_s && !ret_id_s) rsp0_data_r <= fpu_outp;
            else                    rsp0_data_r <= rsp0_data_r;
            if (ret_s && ret_id_s)  rsp1_data_r <= fpu_outp;
            else                    rsp1_data_r <= rsp1_data_r;
        end
    end

    // Outstanding-op counter; bounded by LAT because the tag pipe is LAT deep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_r <= 4'd0;
        end else begin
            case ({hs_s, ret_s})
                2'b10:   inflight_r <= inflight_r + 4'd1;
                2'b01:   inflight_r <= inflight_r - 4'd1;
                default: inflight_r <= inflight_r;
            endcase
        end
    end

    assign req0_ready = gnt0_s;
    assign req1_ready = gnt1_s;
    assign fpu_A      = fpu_a_r;
    assign fpu_B      = fpu_b_r;
    assign fpu_opcode = fpu_op_r;
    assign rsp0_valid = rsp0_valid_r;
    assign rsp1_valid = rsp1_valid_r;
    assign rsp0_data  = rsp0_data_r;
    assign rsp1_data  = rsp1_data_r;
    assign inflight   = inflight_r;

endmodule

// File: tb/tb_fpu_arbiter.sv
// Directed bench for fpu_arbiter: a pipelined instance and a single-op instance, each driving its own latency-5 FPU stub.
module tb_fpu_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [31:0] req0_a = 32'd0, req0_b = 32'd0, req1_a = 32'd0, req1_b = 32'd0;
    logic [1:0]  req0_op = 2'd0, req1_op = 2'd0;

    logic        rdy0, rdy1, rv0, rv1;
    logic [31:0] fa, fb, outp, rd0, rd1;
    logic [1:0]  fop;
    logic [3:0]  infl;

    logic        n_rdy0, n_rdy1, n_rv0, n_rv1;
    logic [31:0] n_fa, n_fb, n_outp, n_rd0, n_rd1;
    logic [1:0]  n_fop;
    logic [3:0]  n_infl;

    int total_cnt = 0;
    int bad_cnt   = 0;

    always #5 clk = ~clk;

    // Small FPU model: true add for positive normals, simple bit ops otherwise.
    function automatic logic [31:0] fmodel(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        logic [7:0]  ea, eb, d;
        logic [24:0] ma, mb, s;
        case (op)
            2'b00: begin
                if (a[30:23] >= b[30:23]) begin
                    ea = a[30:23]; ma = {2'b01, a[22:0]};
                    eb = b[30:23]; mb = {2'b01, b[22:0]};
                end else begin
                    ea = b[30:23]; ma = {2'b01, b[22:0]};
                    eb = a[30:23]; mb = {2'b01, a[22:0]};
                end
                d  = ea - eb;
                mb = (d > 8'd24) ? 25'd0 : (mb >> d);
                s  = ma + mb;
                if (s[24]) begin
                    s  = s >> 1;
                    ea = ea + 8'd1;
                end
                return {1'b0, ea, s[22:0]};
            end
            2'b01:   return a ^ b;
            2'b10:   return a;
            default: return ~a;
        endcase
    endfunction

    logic [31:0] p_stg [4];
    logic [31:0] n_stg [4];
    // Latency-5 stubs: four register stages, sampled by the DUT on the fifth edge.
    always @(posedge clk) begin
        p_stg[0] <= fmodel(fa, fb, fop);
        n_stg[0] <= fmodel(n_fa, n_fb, n_fop);
        for (int i = 1; i < 4; i++) begin
            p_stg[i] <= p_stg[i-1];
            n_stg[i] <= n_stg[i-1];
        end
    end
    assign outp   = p_stg[3];
    assign n_outp = n_stg[3];

    fpu_arbiter #(.LAT(5), .PIPELINED(1)) u_dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(rdy0), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(rdy1), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .fpu_A(fa), .fpu_B(fb), .fpu_opcode(fop), .fpu_outp(outp),
        .rsp0_valid(rv0), .rsp1_valid(rv1), .rsp0_data(rd0), .rsp1_data(rd1), .inflight(infl)
    );

    fpu_arbiter #(.LAT(5), .PIPELINED(0)) u_dut_np (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(n_rdy0), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(n_rdy1), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .fpu_A(n_fa), .fpu_B(n_fb), .fpu_opcode(n_fop), .fpu_outp(n_outp),
        .rsp0_valid(n_rv0), .rsp1_valid(n_rv1), .rsp0_data(n_rd0), .rsp1_data(n_rd1), .inflight(n_infl)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s got=%h want=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] exp_d [11];
    logic [31:0] exp_a;
    int          pulses;

    initial begin
        // Reset state, with a requester already valid.
        req0_valid = 1'b1;
        tick(); tick();
        chk("rst_rdy", {30'd0, rdy1, rdy0}, 32'd0);
        chk("rst_rsp", {30'd0, rv1, rv0}, 32'd0);
        chk("rst_fa", fa, 32'd0);
        chk("rst_fop", {30'd0, fop}, 32'd0);
        chk("rst_infl", {28'd0, infl}, 32'd0);
        chk("rst_rd0", rd0, 32'd0);

        // Single op 2.0 + 3.0, accepted on the first edge after reset.
        req0_a = 32'h4000_0000; req0_b = 32'h4040_0000; req0_op = 2'b00;
        rst = 1'b0;
        #1;
        chk("single_rdy", {30'd0, rdy1, rdy0}, 32'd1);
        tick();
        req0_valid = 1'b0;
        chk("single_fa", fa, 32'h4000_0000);
        chk("single_fb", fb, 32'h4040_0000);
        chk("single_infl", {28'd0, infl}, 32'd1);
        repeat (4) tick();
        chk("single_early", {30'd0, rv1, rv0}, 32'd0);
        tick();
        chk("single_rsp", {30'd0, rv1, rv0}, 32'd1);
        chk("single_data", rd0, 32'h40A0_0000);
        chk("single_infl0", {28'd0, infl}, 32'd0);
        tick();
        chk("single_pulse", {30'd0, rv1, rv0}, 32'd0);
        chk("single_hold", rd0, 32'h40A0_0000);

        // Contention from reset: grants alternate starting with requester 0.
        rst = 1'b1; tick(); rst = 1'b0;
        req0_b = 32'h3F80_0000; req1_b = 32'h4000_0000;
        for (int i = 0; i < 4; i++) begin
            req0_valid = 1'b1; req1_valid = 1'b1;
            req0_a = 32'h3F80_0000 + 32'(i); req0_op = 2'(i);
            req1_a = 32'h4100_0000 + 32'(i << 8); req1_op = 2'(3 - i);
            exp_a    = (i % 2 == 0) ? req0_a : req1_a;
            exp_d[i] = (i % 2 == 0) ? fmodel(req0_a, req0_b, req0_op) : fmodel(req1_a, req1_b, req1_op);
            #1;
            chk("cont_rdy", {30'd0, rdy1, rdy0}, (i % 2 == 0) ? 32'd1 : 32'd2);
            tick();
            chk("cont_fa", fa, exp_a);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("cont_peak", {28'd0, infl}, 32'd4);
        tick();
        chk("cont_early", {30'd0, rv1, rv0}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("cont_rsp", {30'd0, rv1, rv0}, (i % 2 == 0) ? 32'd1 : 32'd2);
            chk("cont_data", (i % 2 == 0) ? rd0 : rd1, exp_d[i]);
        end

        // Requester 1 streams six ops back to back.
        for (int c = 0; c < 11; c++) begin
            if (c < 6) begin
                req1_valid = 1'b1;
                req1_a = 32'h4000_0000 + 32'(c << 4); req1_b = 32'h3F80_0000; req1_op = 2'(c);
                exp_d[c] = fmodel(req1_a, req1_b, req1_op);
                #1;
                chk("strm_rdy", {30'd0, rdy1, rdy0}, 32'd2);
            end else begin
                req1_valid = 1'b0;
            end
            tick();
            if (c == 4) chk("strm_early", {30'd0, rv1, rv0}, 32'd0);
            if (c == 4 || c == 5) chk("strm_infl", {28'd0, infl}, 32'd5);
            if (c >= 5) begin
                chk("strm_rsp", {30'd0, rv1, rv0}, 32'd2);
                chk("strm_data", rd1, exp_d[c-5]);
            end
        end
        chk("strm_infl0", {28'd0, infl}, 32'd0);

        // Reset with three ops in flight discards them.
        req0_a = 32'h4080_0000; req0_b = 32'h3F80_0000; req0_op = 2'b01;
        req0_valid = 1'b1;
        repeat (3) tick();
        req0_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("rmid_fa", fa, 32'd0);
        chk("rmid_infl", {28'd0, infl}, 32'd0);
        chk("rmid_rd", rd0 | rd1, 32'd0);
        tick();
        rst = 1'b0;
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (rv0 || rv1) pulses++;
        end
        chk("rmid_pulses", 32'(pulses), 32'd0);
        chk("rmid_infl2", {28'd0, infl}, 32'd0);
        req0_a = 32'h3F80_0000; req0_b = 32'h4000_0000; req0_op = 2'b00;
        req0_valid = 1'b1;
        tick();
        req0_valid = 1'b0;
        repeat (5) tick();
        chk("rmid_rsp", {30'd0, rv1, rv0}, 32'd1);
        chk("rmid_data", rd0, 32'h4040_0000);

        // Single-op-in-flight instance: other requester waits for the return.
        rst = 1'b1; tick(); rst = 1'b0;
        req0_a = 32'h4000_0000; req0_b = 32'h4000_0000; req0_op = 2'b00;
        req1_a = 32'h4120_0000; req1_b = 32'h3F80_0000; req1_op = 2'b10;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("np_rdy0", {30'd0, n_rdy1, n_rdy0}, 32'd1);
        tick();
        for (int c = 0; c < 5; c++) begin
            chk("np_busy", {30'd0, n_rdy1, n_rdy0}, 32'd0);
            chk("np_infl", {28'd0, n_infl}, 32'd1);
            tick();
        end
        chk("np_rsp", {30'd0, n_rv1, n_rv0}, 32'd1);
        chk("np_data", n_rd0, 32'h4080_0000);
        chk("np_rdy1", {30'd0, n_rdy1, n_rdy0}, 32'd2);
        chk("np_infl0", {28'd0, n_infl}, 32'd0);
        tick();
        chk("np_fa", n_fa, 32'h4120_0000);
        chk("np_infl1", {28'd0, n_infl}, 32'd1);
        chk("np_busy2", {30'd0, n_rdy1, n_rdy0}, 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/fpu_arbiter.md
FPU_ARBITER -- requirements
Module: fpu_arbiter

Interface
REQ-001 SHALL have parameter LAT, default 5, meaning FPU latency in clk edges from operand launch to result sampling (legal 1..8).
REQ-002 SHALL have parameter PIPELINED, default 1: 1 = FPU accepts one op per cycle; 0 = at most one op in flight.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports req0_valid / req1_valid  input  1  requester N presents an operation.
REQ-006 SHALL have ports req0_ready / req1_ready  output  1  grant; handshake = valid && ready at a rising edge.
REQ-007 SHALL have ports req0_a, req0_b / req1_a, req1_b  input  32  IEEE-754 single operands.
REQ-008 SHALL have ports req0_op / req1_op  input  2  FPU opcode.
REQ-009 SHALL have ports fpu_A, fpu_B  output  32 and fpu_opcode  output  2  registered drive to FPU A, B, opcode.
REQ-010 SHALL have port fpu_outp  input  32  FPU result.
REQ-011 SHALL have ports rsp0_valid / rsp1_valid  output  1  one-cycle result strobe to requester N.
REQ-012 SHALL have ports rsp0_data / rsp1_data  output  32  result, valid while rspN_valid.
REQ-013 SHALL have port inflight  output  4  count of issued ops not yet returned.

Function
REQ-014 SHALL arbitrate round-robin with a 1-bit pointer: both valid -> grant pointed requester; one valid -> grant it.
REQ-015 SHALL toggle the pointer to the non-granted requester after every handshake; no handshake -> pointer unchanged.
REQ-016 SHALL derive reqN_ready combinationally from valids, pointer and issue state; never both readys high in one cycle.
REQ-017 SHALL hold ready low for a requester whose valid is low (no idle grants).
REQ-018 SHALL, on handshake at edge k, load fpu_A/fpu_B/fpu_opcode from the granted requester at edge k.
REQ-019 SHALL hold fpu_A/fpu_B/fpu_opcode at last issued values when no handshake occurs.
REQ-020 SHALL track each issue in an LAT-deep shift register of {valid, requester id}.
REQ-021 SHALL sample fpu_outp at edge k+LAT for an issue at edge k, register it into rspN_data of the tagged requester and assert rspN_valid for exactly the one cycle after edge k+LAT.
REQ-022 SHALL leave the non-addressed rsp data unchanged and its valid low.
REQ-023 SHALL, with PIPELINED=1, allow one handshake per cycle back-to-back; responses return in issue order, one per cycle.
REQ-024 SHALL, with PIPELINED=0, run FSM IDLE -> BUSY on handshake, BUSY -> IDLE at the edge rspN_valid asserts; both readys low in BUSY.
REQ-025 SHALL keep inflight = issues minus returns; same-edge issue and return leaves it unchanged; max LAT, never wraps.
REQ-026 SHALL apply no backpressure on responses; requesters always accept rspN_valid.
REQ-027 SHALL pass fpu_outp unmodified; no arithmetic on data.

Reset
REQ-028 SHALL, while rst high, force req0_ready=req1_ready=0, rsp0_valid=rsp1_valid=0, rsp0_data=rsp1_data=0, fpu_A=fpu_B=0, fpu_opcode=0, inflight=0, pointer=requester 0, FSM=IDLE, tag register cleared.
REQ-029 SHALL discard all in-flight operations on reset mid-operation; no rspN_valid for ops issued before reset.
REQ-030 SHALL accept a handshake on the first rising edge after rst deasserts.

Verification
REQ-031 Single op: LAT=5, behavioural FPU stub of latency 5, req0 a=0x40000000 b=0x40400000 op=00 handshake at edge k -> fpu_A=0x40000000 after k, rsp0_valid one cycle after edge k+5, rsp0_data=0x40A00000, rsp1_valid stays 0.
REQ-032 Contention: both valid continuously 4 cycles from reset -> grants 0,1,0,1; responses alternate rsp0/rsp1 at edges k+5..k+8; inflight peaks at 4.
REQ-033 Single requester streaming: req1 valid 6 cycles -> ready high all 6 cycles, 6 consecutive rsp1_valid pulses, correct order.
REQ-034 PIPELINED=0: both valid -> one grant, readys low 5 cycles, next grant to other requester at the edge rsp0_valid asserts; inflight never exceeds 1.
REQ-035 Reset mid-flight: 3 ops issued, rst pulsed 1 cycle two edges later -> no rsp valid pulses for 10 cycles, inflight=0, outputs zero, next op returns normally.
